// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// Bundles the signals between the writeback stage and its neighbours: the
// memory-stage result and its misalignment qualifiers, the register-file write
// port, the forwarding tap, the trap handshake and the retire counter.
//
// Modports:
//   slave  - the writeback stage (consumes i_*, drives o_*)
//   master - the environment (drives i_*, consumes o_*)
//
// Signals:
//   i_mem2all                  memory-stage result (valid, reg_wr_en, rd, rd_data)
//   i_load_miss_aligned_error  qualifies i_mem2all
//   i_store_miss_aligned_error qualifies i_mem2all
//   i_rf_ready                 register-file write port accepts this cycle
//   i_trap_ack                 trap handler has redirected fetch
//   o_wb_ready                 backpressure to the memory stage
//   o_rf_wen/o_rf_waddr/o_rf_wdata  register-file write request
//   o_fwd_valid/o_fwd_rd/o_fwd_data head-entry forwarding tap
//   o_trap                     level trap request
//   o_retire_count             retired-instruction count
// -----------------------------------------------------------------------------
interface wb_stage_if;

    typedef struct packed {
        logic        valid;
        logic        reg_wr_en;
        logic [4:0]  rd;
        logic [63:0] rd_data;
    } interconnection_struct;

    interconnection_struct i_mem2all;
    logic                  i_load_miss_aligned_error;
    logic                  i_store_miss_aligned_error;
    logic                  i_rf_ready;
    logic                  i_trap_ack;
    logic                  o_wb_ready;
    logic                  o_rf_wen;
    logic [4:0]            o_rf_waddr;
    logic [63:0]           o_rf_wdata;
    logic                  o_fwd_valid;
    logic [4:0]            o_fwd_rd;
    logic [63:0]           o_fwd_data;
    logic                  o_trap;
    logic [63:0]           o_retire_count;

    modport slave (
        input  i_mem2all, i_load_miss_aligned_error, i_store_miss_aligned_error,
        input  i_rf_ready, i_trap_ack,
        output o_wb_ready, o_rf_wen, o_rf_waddr, o_rf_wdata,
        output o_fwd_valid, o_fwd_rd, o_fwd_data, o_trap, o_retire_count
    );

    modport master (
        output i_mem2all, i_load_miss_aligned_error, i_store_miss_aligned_error,
        output i_rf_ready, i_trap_ack,
        input  o_wb_ready, o_rf_wen, o_rf_waddr, o_rf_wdata,
        input  o_fwd_valid, o_fwd_rd, o_fwd_data, o_trap, o_retire_count
    );

endinterface

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage: buffers memory-stage results in a 2-entry FIFO, drains them
// into the register-file write port, raises a level trap on a misaligned
// load/store and exposes the FIFO head for forwarding.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - wb_stage_if.slave (see wb_stage_if.sv for the signal list)
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   defined     - 64-bit wrapping counter of popped entries on o_retire_count
//   not defined - o_retire_count tied to zero, no counter flops
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_stage_if.slave bus
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_e;

    typedef struct packed {
        logic            wr_en;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    entry_t     fifo_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    state_e     state_q, state_d;

    entry_t     head_s;
    entry_t     in_entry_s;
    logic       head_valid_s;
    logic       writer_s;
    logic       wb_ready_s;
    logic       accept_s;
    logic       err_s;
    logic       push_s;
    logic       pop_s;
    logic       fault_s;

    assign head_s       = fifo_q[rd_ptr_q];
    assign head_valid_s = (count_q != 2'd0);
    // rd == 0 targets the hard-wired zero register, so it never writes.
    assign writer_s     = head_s.wr_en && (head_s.rd != 5'd0);
    // Non-writers retire without waiting on the register file.
    assign pop_s        = head_valid_s && (!writer_s || bus.i_rf_ready);

    // Ready depends only on registered state, never on i_rf_ready.
    assign wb_ready_s   = (count_q < FULL_CNT) && (state_q == RUN);
    assign err_s        = bus.i_load_miss_aligned_error || bus.i_store_miss_aligned_error;
    assign accept_s     = bus.i_mem2all.valid && wb_ready_s;
    assign push_s       = accept_s && !err_s;
    assign fault_s      = accept_s && err_s;

    assign in_entry_s.wr_en = bus.i_mem2all.reg_wr_en;
    assign in_entry_s.rd    = bus.i_mem2all.rd;
    assign in_entry_s.data  = bus.i_mem2all.rd_data;

    // FIFO occupancy and pointer next-state.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q ^ pop_s;
        wr_ptr_d = wr_ptr_q ^ push_s;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // RUN/TRAP next-state; older entries keep draining while in TRAP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (fault_s) begin
                    state_d = TRAP;
                end else begin
                    state_d = RUN;
                end
            end
            TRAP: begin
                if (bus.i_trap_ack && (count_q == 2'd0)) begin
                    state_d = RUN;
                end else begin
                    state_d = TRAP;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            state_q  <= RUN;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            state_q  <= state_d;
        end
    end

    // FIFO storage; cleared on reset so head-derived outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else if (push_s) begin
            fifo_q[wr_ptr_q] <= in_entry_s;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    // Retire counter next-state; wraps naturally at 2^64.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (pop_s) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= 64'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.o_retire_count = retire_cnt_q;
`else
    assign bus.o_retire_count = 64'd0;
`endif

    assign bus.o_wb_ready  = wb_ready_s;
    assign bus.o_rf_wen    = head_valid_s && writer_s;
    assign bus.o_rf_waddr  = head_s.rd;
    assign bus.o_rf_wdata  = head_s.data;
    assign bus.o_fwd_valid = head_valid_s && writer_s;
    assign bus.o_fwd_rd    = head_s.rd;
    assign bus.o_fwd_data  = head_s.data;
    assign bus.o_trap      = (state_q == TRAP);

endmodule
